// File: rtl/joy_db15_tx_if.sv
// Serial link between a DB15 joystick reader and the adapter it polls.
//   joy_clk  : shift clock, driven by the reader
//   joy_load : active-low parallel load, driven by the reader
//   joy_data : active-low serial data, driven by the adapter
// Modports: master = reader side, slave = adapter side.
interface joy_db15_tx_if;
    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (
        output joy_clk,
        output joy_load,
        input  joy_data
    );

    modport slave (
        input  joy_clk,
        input  joy_load,
        output joy_data
    );
endinterface

// File: rtl/joy_db15_tx.sv
// DB15 shift-register joystick adapter emulation (responder end of the link).
// Serialises {joystick2, joystick1} LSB-first, inverted to line polarity, in
// response to the reader's load and shift strobes.
// Ports:
//   clk, reset  : system clock (>= 4x joy_clk toggle rate), async active-high reset
//   enable      : adapter present; when low joy_data idles high and strobes are ignored
//   joystick1/2 : active-high button words, frame = {joystick2, joystick1}
//   bus         : joy_clk / joy_load in, joy_data out (slave modport)
//   frame_done  : one-cycle pulse after the last frame bit has been shifted
//   bit_count   : shifts since the last load, saturating at FRAME_BITS
//   overrun     : sticky, a shift arrived after the frame was exhausted
module joy_db15_tx #(
    parameter int unsigned FRAME_BITS  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [15:0]         joystick1,
    input  logic [15:0]         joystick2,
    joy_db15_tx_if.slave        bus,
    output logic                frame_done,
    output logic [5:0]          bit_count,
    output logic                overrun
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic                    data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;

    logic [SYNC_STAGES-1:0]  clk_sync_q;
    logic [SYNC_STAGES-1:0]  load_sync_q;
    logic                    clk_prev_q;

    logic                    clk_rise_c;
    logic                    load_low_c;
    logic [FRAME_BITS-1:0]   frame_c;

    // Synchronisers for the asynchronous reader strobes; load idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '0;
            load_sync_q <= '1;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.joy_clk};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], bus.joy_load};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_rise_c = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign load_low_c = ~load_sync_q[SYNC_STAGES-1];

    // Frame word in line polarity (0 = pressed), truncated to the frame length.
    assign frame_c = ~FRAME_BITS'({joystick2, joystick1});

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '1;
            data_q  <= 1'b1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state and next-datapath logic. Load wins over a coincident shift
    // edge, and a low load reloads the register every cycle like a 74165.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        if (!enable) begin
            state_d = IDLE;
            sr_d    = '1;
            data_d  = 1'b1;
            cnt_d   = '0;
        end else if (load_low_c) begin
            state_d = LOAD;
            sr_d    = frame_c;
            data_d  = frame_c[0];
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_d = 1'b1;
                end
                LOAD, SHIFT: begin
                    state_d = SHIFT;
                    if (clk_rise_c) begin
                        sr_d   = {1'b1, sr_q[FRAME_BITS-1:1]};
                        data_d = sr_q[1];
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(FRAME_BITS)) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    data_d = 1'b1;
                    if (clk_rise_c) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    data_d  = 1'b1;
                end
            endcase
        end
    end

    // Disabled adapter looks like an open line (idle high).
    assign bus.joy_data = enable ? data_q : 1'b1;
    assign frame_done   = done_q;
    assign bit_count    = cnt_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx acting as the DB15 reader.
module tb_joy_db15_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        frame_done;
    logic [5:0]  bit_count;
    logic        overrun;

    joy_db15_tx_if bus();

    joy_db15_tx #(
        .FRAME_BITS (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .joystick1 (j1),
        .joystick2 (j2),
        .bus       (bus),
        .frame_done(frame_done),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int done_pulses = 0;

    logic       d_c2, d_c3, fd_c3;
    logic [5:0] cnt_c2, cnt_c3;
    logic [31:0] exp_f;

    always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        bus.joy_load = 1'b0;
        cyc(4);
        bus.joy_load = 1'b1;
        cyc(5);
    endtask

    // One shift edge; samples 2 and 3 cycles after the pin rises.
    task automatic jedge();
        bus.joy_clk = 1'b1;
        cyc(2);
        d_c2   = bus.joy_data;
        cnt_c2 = bit_count;
        cyc(1);
        d_c3   = bus.joy_data;
        cnt_c3 = bit_count;
        fd_c3  = frame_done;
        cyc(1);
        bus.joy_clk = 1'b0;
        cyc(4);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        j1           = 16'h0000;
        j2           = 16'h0000;
        bus.joy_clk  = 1'b0;
        bus.joy_load = 1'b1;
        cyc(3);
        chk("rst_data", bus.joy_data, 1);
        chk("rst_cnt", bit_count, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(3);

        // Basic frame
        j1 = 16'h0011;
        j2 = 16'h8000;
        exp_f = 32'h7FFF_FFEE;
        do_load();
        chk("t1_bit0", bus.joy_data, 0);
        chk("t1_cnt0", bit_count, 0);
        done_pulses = 0;
        for (int k = 1; k <= 32; k++) begin
            jedge();
            chk($sformatf("t1_d%0d", k), d_c3, (k < 32) ? exp_f[k] : 1'b1);
            chk($sformatf("t1_c%0d", k), cnt_c3, k);
            chk($sformatf("t1_fd%0d", k), fd_c3, (k == 32) ? 1 : 0);
        end
        chk("t1_pulses", done_pulses, 1);

        // Latency
        do_load();
        jedge();
        chk("t2_d_c2", d_c2, 0);
        chk("t2_cnt_c2", cnt_c2, 0);
        chk("t2_d_c3", d_c3, 1);
        chk("t2_cnt_c3", cnt_c3, 1);

        // Overrun
        do_load();
        for (int k = 1; k <= 34; k++) begin
            jedge();
            if (k == 32) begin
                chk("t3_d32", bus.joy_data, 1);
                chk("t3_c32", bit_count, 32);
                chk("t3_o32", overrun, 0);
            end
            if (k == 33) begin
                chk("t3_o33", overrun, 1);
                chk("t3_c33", bit_count, 32);
            end
        end
        chk("t3_o34", overrun, 1);
        chk("t3_c34", bit_count, 32);
        chk("t3_d34", bus.joy_data, 1);
        do_load();
        chk("t3_ovr_clr", overrun, 0);
        chk("t3_cnt_clr", bit_count, 0);
        chk("t3_d_load", bus.joy_data, 0);

        // Load priority and input freeze
        j1 = 16'h0001;
        j2 = 16'h0000;
        bus.joy_load = 1'b0;
        cyc(5);
        bus.joy_clk = 1'b1;
        cyc(5);
        chk("t4_cnt_in_load", bit_count, 0);
        chk("t4_d_in_load", bus.joy_data, 0);
        bus.joy_clk = 1'b0;
        cyc(4);
        bus.joy_load = 1'b1;
        cyc(5);
        j1 = 16'h0002;
        cyc(5);
        chk("t4_d_frozen", bus.joy_data, 0);
        chk("t4_cnt_frozen", bit_count, 0);
        jedge();
        chk("t4_d1", d_c3, 1);
        chk("t4_c1", cnt_c3, 1);
        jedge();
        chk("t4_d2", d_c3, 1);
        chk("t4_c2", cnt_c3, 2);

        // Enable low ignores strobes
        enable = 1'b0;
        bus.joy_load = 1'b0;
        cyc(5);
        chk("t5_dis_d", bus.joy_data, 1);
        chk("t5_dis_cnt", bit_count, 0);
        bus.joy_load = 1'b1;
        cyc(4);
        jedge();
        chk("t5_dis_edge_d", d_c3, 1);
        chk("t5_dis_edge_cnt", cnt_c3, 0);
        chk("t5_dis_edge_fd", fd_c3, 0);
        enable = 1'b1;
        cyc(3);
        chk("t5_en_idle_d", bus.joy_data, 1);
        jedge();
        chk("t5_en_edge_d", d_c3, 1);
        chk("t5_en_edge_cnt", cnt_c3, 0);

        // Reset mid-frame
        j1 = 16'h0411;
        j2 = 16'h8000;
        exp_f = 32'h7FFF_FBEE;
        do_load();
        for (int k = 1; k <= 10; k++) jedge();
        chk("t5_pre_cnt", bit_count, 10);
        chk("t5_pre_d", bus.joy_data, exp_f[10]);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_d", bus.joy_data, 1);
        chk("t5_rst_cnt", bit_count, 0);
        chk("t5_rst_fd", frame_done, 0);
        chk("t5_rst_ovr", overrun, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        jedge();
        chk("t5_idle_edge_d", d_c3, 1);
        chk("t5_idle_edge_cnt", cnt_c3, 0);
        do_load();
        chk("t5_reload_d", bus.joy_data, exp_f[0]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
